field_varint_seq: RTL and testbench



---
 rtl/field_varint_seq_if.sv | 26 ++
 rtl/field_varint_seq.sv | 125 ++++++++++++
 tb/tb_field_varint_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/field_varint_seq_if.sv
// Request / encoded-byte stream bundle for field_varint_seq.
// master: the request producer and byte consumer side.
// slave : the encoder block itself.
interface field_varint_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_value;
  logic [4:0]  in_field_type;
  logic [28:0] in_field_num;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        busy;
  logic        err;

  modport master (
    output in_valid, in_value, in_field_type, in_field_num, out_ready,
    input  in_ready, out_valid, out_byte, out_last, busy, err
  );

  modport slave (
    input  in_valid, in_value, in_field_type, in_field_num, out_ready,
    output in_ready, out_valid, out_byte, out_last, busy, err
  );
endinterface

// File: rtl/field_varint_seq.sv
// field_varint_seq: serialises one protobuf varint field per request as a
// byte stream (key varint, then value varint, least-significant group first).
// Optional feature: define FIELD_VARINT_SEQ_KEY_EN to emit the key varint
// (field number, wire type 0) ahead of every value. Without it, only the
// value bytes are emitted and in_field_num is ignored.
module field_varint_seq (
  input  logic               clk,
  input  logic               rst_n,
  field_varint_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEY  = 2'd1,
    VAL  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] val_q;
  logic        err_q;

  logic        accept;
  logic        supported;
  logic        hs;
  logic        cont;
  logic [63:0] rem;
  logic [63:0] val_load;
  logic [31:0] zz32;

`ifdef FIELD_VARINT_SEQ_KEY_EN
  logic [31:0] key_q;
`endif

  assign accept = bus.in_valid && (state_q == IDLE);
  assign hs     = (state_q != IDLE) && bus.out_ready;

  // Decode which descriptor types are encoded as plain varints.
  always_comb begin
    case (bus.in_field_type)
      5'd3, 5'd4, 5'd5, 5'd8, 5'd13, 5'd14, 5'd17, 5'd18: supported = 1'b1;
      default:                                            supported = 1'b0;
    endcase
  end

  // Zigzag-map sint32/sint64; everything else is loaded verbatim.
  always_comb begin
    zz32 = {bus.in_value[30:0], 1'b0} ^ {32{bus.in_value[31]}};
    case (bus.in_field_type)
      5'd17:   val_load = {32'd0, zz32};
      5'd18:   val_load = {bus.in_value[62:0], 1'b0} ^ {64{bus.in_value[63]}};
      default: val_load = bus.in_value;
    endcase
  end

  // Select the register being emitted and form the outgoing byte.
  always_comb begin
`ifdef FIELD_VARINT_SEQ_KEY_EN
    rem = (state_q == KEY) ? {32'd0, key_q} : val_q;
`else
    rem = val_q;
`endif
    cont = |rem[63:7];
  end

  // Next-state logic: a field advances only on a handshake of its final group.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && supported) begin
`ifdef FIELD_VARINT_SEQ_KEY_EN
          state_d = KEY;
`else
          state_d = VAL;
`endif
        end
      end
      KEY:     if (hs && !cont) state_d = VAL;
      VAL:     if (hs && !cont) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, shift registers and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state, including the datapath registers, is cleared on reset
    // so out_byte reads 0 and an abandoned field cannot leak afterwards.
    if (!rst_n) begin
      state_q <= IDLE;
      val_q   <= 64'd0;
      err_q   <= 1'b0;
`ifdef FIELD_VARINT_SEQ_KEY_EN
      key_q   <= 32'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      err_q   <= accept && !supported;
      if (accept && supported) begin
        val_q <= val_load;
`ifdef FIELD_VARINT_SEQ_KEY_EN
        key_q <= {bus.in_field_num, 3'b000};
`endif
      end else if (hs) begin
`ifdef FIELD_VARINT_SEQ_KEY_EN
        if (state_q == KEY) key_q <= key_q >> 7;
        else                val_q <= val_q >> 7;
`else
        val_q <= val_q >> 7;
`endif
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q != IDLE);
  assign bus.out_byte  = (state_q == IDLE) ? 8'd0 : {cont, rem[6:0]};
  assign bus.out_last  = (state_q == VAL) && !cont;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_field_varint_seq.sv
// Randomised self-checking bench for field_varint_seq. Expected byte streams
// come from an arithmetic varint/zigzag model; works with or without
// FIELD_VARINT_SEQ_KEY_EN defined.
module tb_field_varint_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  field_varint_seq_if ifc ();

  field_varint_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_supported(input logic [4:0] ft);
    return ft inside {5'd3, 5'd4, 5'd5, 5'd8, 5'd13, 5'd14, 5'd17, 5'd18};
  endfunction

  // Zigzag by definition: non-negative n -> 2n, negative n -> 2|n|-1 = 2*~n+1.
  function automatic logic [63:0] model_value(input logic [4:0] ft, input logic [63:0] v);
    logic [31:0] w;
    if (ft == 5'd17) begin
      w = v[31:0];
      if (w[31] == 1'b0) return {32'd0, w * 32'd2};
      else               return {32'd0, (~w) * 32'd2 + 32'd1};
    end else if (ft == 5'd18) begin
      if (v[63] == 1'b0) return v * 64'd2;
      else               return (~v) * 64'd2 + 64'd1;
    end
    return v;
  endfunction

  // Base-128 digits, low first, with bit 7 set on all but the last.
  function automatic void push_varint(input logic [63:0] v);
    logic [63:0] r;
    logic [7:0]  b;
    r = v;
    do begin
      b = 8'(r % 64'd128);
      r = r / 64'd128;
      if (r != 0) b = b + 8'd128;
      exp_q.push_back(b);
    end while (r != 0);
  endfunction

  // mode 0: out_ready high, 1: toggle 1/0, 2: random.
  // abort_after > 0 returns once that many bytes have been accepted.
  task automatic run_field(input logic [4:0] ft, input logic [63:0] v,
                           input logic [28:0] fn, input int mode, input int abort_after);
    int   idx;
    int   cyc;
    bit   rdy;
    bit   stalled;
    logic [7:0] pb;
    logic       pl;
    bit   sup;
    sup = is_supported(ft);
    exp_q.delete();
    if (sup) begin
`ifdef FIELD_VARINT_SEQ_KEY_EN
      push_varint({32'd0, fn, 3'b000});
`endif
      push_varint(model_value(ft, v));
    end
    @(negedge clk);
    check("in_ready_idle", ifc.in_ready, 1);
    ifc.in_valid      = 1'b1;
    ifc.in_value      = v;
    ifc.in_field_type = ft;
    ifc.in_field_num  = fn;
    ifc.out_ready     = (mode == 2) ? 1'($urandom % 2) : 1'b1;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.in_value = {$urandom, $urandom};
    @(negedge clk);
    if (!sup) begin
      check("err_pulse", ifc.err, 1);
      check("err_no_valid", ifc.out_valid, 0);
      @(negedge clk);
      check("err_clear", ifc.err, 0);
      check("err_idle_busy", ifc.busy, 0);
      check("err_idle_valid", ifc.out_valid, 0);
      return;
    end
    check("first_valid", ifc.out_valid, 1);
    check("busy", ifc.busy, 1);
    idx = 0; cyc = 0; stalled = 0;
    while (idx < exp_q.size()) begin
      if (cyc >= 400) begin
        check("timeout_bytes", idx, exp_q.size());
        return;
      end
      check("valid_hold", ifc.out_valid, 1);
      if (stalled) begin
        check("stall_byte", ifc.out_byte, pb);
        check("stall_last", ifc.out_last, pl);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom % 2);
      endcase
      ifc.out_ready = rdy;
      if (rdy) begin
        check("byte", ifc.out_byte, exp_q[idx]);
        check("last", ifc.out_last, (idx == exp_q.size() - 1));
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pb = ifc.out_byte;
        pl = ifc.out_last;
      end
      cyc++;
      if (abort_after > 0 && idx == abort_after) return;
      @(negedge clk);
    end
    check("gap_valid", ifc.out_valid, 0);
    check("gap_ready", ifc.in_ready, 1);
  endtask

  logic [4:0] sup_types[8] = '{5'd3, 5'd4, 5'd5, 5'd8, 5'd13, 5'd14, 5'd17, 5'd18};

  initial begin
    logic [4:0]  ft;
    logic [63:0] v;
    logic [28:0] fn;
    rst_n             = 1'b0;
    ifc.in_valid      = 1'b0;
    ifc.in_value      = 64'd0;
    ifc.in_field_type = 5'd0;
    ifc.in_field_num  = 29'd0;
    ifc.out_ready     = 1'b0;
    #12;
    check("rst_in_ready", ifc.in_ready, 1);
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_busy", ifc.busy, 0);
    check("rst_err", ifc.err, 0);
    check("rst_out_byte", ifc.out_byte, 0);
    check("rst_out_last", ifc.out_last, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed cases.
    run_field(5'd4,  64'd1,   29'd1,  0, 0);
    run_field(5'd13, 64'd300, 29'd2,  0, 0);
    run_field(5'd17, '1,      29'd1,  0, 0);
    run_field(5'd18, 64'd2,   29'd16, 0, 0);
    run_field(5'd3,  '1,      29'd1,  1, 0);
    run_field(5'd9,  64'd5,   29'd3,  0, 0);
    run_field(5'd5,  64'd0,   29'd0,  0, 0);
    run_field(5'd18, 64'h8000_0000_0000_0000, 29'h1FFF_FFFF, 2, 0);

    // Reset in the middle of a long value.
    run_field(5'd3, '1, 29'd1, 0, 3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_valid", ifc.out_valid, 0);
    check("midrst_busy", ifc.busy, 0);
    check("midrst_ready", ifc.in_ready, 1);
    check("midrst_byte", ifc.out_byte, 0);
    check("midrst_last", ifc.out_last, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_field(5'd13, 64'd300, 29'd2, 0, 0);

    // Randomised fields.
    for (int i = 0; i < 60; i++) begin
      if ($urandom % 8 == 0) ft = 5'($urandom);
      else                   ft = sup_types[$urandom % 8];
      v = {$urandom, $urandom} >> ($urandom % 64);
      case ($urandom % 4)
        0:       fn = 29'd0;
        1:       fn = 29'h1FFF_FFFF;
        2:       fn = 29'($urandom % 32);
        default: fn = 29'($urandom);
      endcase
      run_field(ft, v, fn, int'($urandom % 3), 0);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
